// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states, the canonical NOP and the IF/ID beat.
package core_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        misalign;
  } if_id_t;

endpackage

// File: rtl/pc_gen.sv
// Program counter register with next-PC selection (redirect / +4 / hold).
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_advance,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;

  // Wraps mod 2^32; the carry out is intentionally dropped.
  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-PC mux: redirect beats sequential advance, otherwise hold.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = i_redirect_pc;
    end else if (i_advance) begin
      w_pc_next = w_pc_plus4;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives imem with the PC and captures the returned
// word into the IF/ID register, handling backpressure, redirect/flush and a
// halt on misaligned redirect targets.
//
//  state | meaning
//  RUN   | normal sequential fetch
//  HALT  | fetch stopped after a misaligned redirect; only a redirect/reset exits
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        id_misalign
);

  fetch_state_e r_state;
  if_id_t       r_if_id;

  logic        w_adv;
  logic        w_pc_advance;
  logic        w_redirect_misaligned;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;

  assign w_adv                 = !r_if_id.valid || id_ready;
  assign w_pc_advance          = (r_state == RUN) && w_adv && !redirect_valid;
  assign w_redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .reset         (reset),
    .i_redirect    (redirect_valid),
    .i_redirect_pc (redirect_pc),
    .i_advance     (w_pc_advance),
    .o_pc          (w_pc),
    .o_pc_plus4    (w_pc_plus4)
  );

  // Fetch FSM and IF/ID register; priority is reset > redirect > advance > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_if_id <= '{valid: 1'b0, pc: 32'd0, pc_plus4: 32'd4,
                   instr: NOP_INSTR, misalign: 1'b0};
    end else if (redirect_valid) begin
      if (w_redirect_misaligned) begin
        // Present the fault as a single NOP beat so decode can trap on it.
        r_state          <= HALT;
        r_if_id.valid    <= 1'b1;
        r_if_id.misalign <= 1'b1;
        r_if_id.pc       <= redirect_pc;
        r_if_id.pc_plus4 <= redirect_pc + 32'd4;
        r_if_id.instr    <= NOP_INSTR;
      end else begin
        // Flush: the word fetched at the old PC this cycle is dropped.
        r_state       <= RUN;
        r_if_id.valid <= 1'b0;
      end
    end else if (w_adv) begin
      if (r_state == RUN) begin
        r_if_id.valid    <= 1'b1;
        r_if_id.pc       <= w_pc;
        r_if_id.pc_plus4 <= w_pc_plus4;
        r_if_id.instr    <= imem_rdata;
        r_if_id.misalign <= 1'b0;
      end else begin
        r_if_id.valid <= 1'b0;
      end
    end
  end

  assign imem_addr   = w_pc;
  assign id_valid    = r_if_id.valid;
  assign id_pc       = r_if_id.pc;
  assign id_pc_plus4 = r_if_id.pc_plus4;
  assign id_instr    = r_if_id.instr;
  assign id_misalign = r_if_id.misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal checks, a behavioural
// model compared every cycle, and a short pseudo-random tail.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        id_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instr       (id_instr),
    .id_misalign    (id_misalign)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the stage must hold after each edge.
  bit          m_started = 0;
  logic [31:0] m_fetch_pc;
  bit          m_halted;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_mis;

  always @(posedge clk) begin
    if (reset) begin
      m_started  = 1;
      m_fetch_pc = 32'h0;
      m_halted   = 0;
      m_valid    = 0;
      m_pc       = 32'h0;
      m_instr    = NOP;
      m_mis      = 0;
    end else if (m_started) begin
      if (redirect_valid) begin
        m_fetch_pc = redirect_pc;
        if (redirect_pc % 4 != 0) begin
          m_halted = 1;
          m_valid  = 1;
          m_mis    = 1;
          m_pc     = redirect_pc;
          m_instr  = NOP;
        end else begin
          m_halted = 0;
          m_valid  = 0;
        end
      end else if (!m_valid || id_ready) begin
        if (m_halted) begin
          m_valid = 0;
        end else begin
          m_valid    = 1;
          m_pc       = m_fetch_pc;
          m_instr    = mem_word(m_fetch_pc);
          m_mis      = 0;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (m_started) begin
      check("m_imem_addr", imem_addr, m_fetch_pc);
      check("m_id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      check("m_id_pc", id_pc, m_pc);
      check("m_id_pc_plus4", id_pc_plus4, m_pc + 32'd4);
      check("m_id_instr", id_instr, m_instr);
      check("m_id_misalign", {31'd0, id_misalign}, {31'd0, m_mis});
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = 0; id_ready = 1;
    tick(2);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'h13);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_plus4", id_pc_plus4, 32'h4);

    // Sequential fetch from RESET_PC.
    reset = 0;
    tick();
    check("seq0_instr", id_instr, 32'h11); check("seq0_pc", id_pc, 32'h0);
    tick();
    check("seq1_instr", id_instr, 32'h22); check("seq1_pc", id_pc, 32'h4);
    tick();
    check("seq2_instr", id_instr, 32'h33); check("seq2_pc", id_pc, 32'h8);

    // Backpressure for 3 cycles on the pc 8 beat.
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc", id_pc, 32'h8);
      check("hold_instr", id_instr, 32'h33);
      check("hold_addr", imem_addr, 32'hC);
    end
    id_ready = 1;
    tick();
    check("rel_pc", id_pc, 32'hC); check("rel_instr", id_instr, 32'h44);

    // Aligned redirect: one bubble, then the target.
    redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    check("redir_bubble", {31'd0, id_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h40);
    redirect_valid = 0;
    tick();
    check("redir_pc", id_pc, 32'h40); check("redir_instr", id_instr, 32'hDEAD_0040);

    // Same with decode stalled at the redirect edge.
    id_ready = 0; redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    check("redir_st_bubble", {31'd0, id_valid}, 32'd0);
    redirect_valid = 0; id_ready = 1;
    tick();
    check("redir_st_pc", id_pc, 32'h40); check("redir_st_valid", {31'd0, id_valid}, 32'd1);

    // Misaligned redirect: fault beat, held, then empty until redirect.
    redirect_valid = 1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 0; id_ready = 0;
    check("mis_flag", {31'd0, id_misalign}, 32'd1);
    check("mis_pc", id_pc, 32'h42); check("mis_instr", id_instr, 32'h13);
    tick();
    check("mis_held", {31'd0, id_valid}, 32'd1);
    id_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("halt_empty", {31'd0, id_valid}, 32'd0);
      check("halt_addr", imem_addr, 32'h42);
    end
    redirect_valid = 1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 0;
    tick();
    check("resume_pc", id_pc, 32'h80); check("resume_valid", {31'd0, id_valid}, 32'd1);

    // Address wrap at the top of the space.
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    tick();
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", id_pc_plus4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    tick();
    check("wrap_next", id_instr, 32'h11);

    // Reset while halted.
    redirect_valid = 1; redirect_pc = 32'h43;
    tick();
    redirect_valid = 0; reset = 1;
    tick();
    check("rst_halt_valid", {31'd0, id_valid}, 32'd0);
    check("rst_halt_instr", id_instr, 32'h13);
    check("rst_halt_addr", imem_addr, 32'h0);
    reset = 0;
    tick(3);
    check("post_rst_pc", id_pc, 32'h8);

    // Reset during a stall.
    id_ready = 0;
    tick(2);
    reset = 1;
    tick();
    check("rst_hold_valid", {31'd0, id_valid}, 32'd0);
    check("rst_hold_instr", id_instr, 32'h13);
    check("rst_hold_addr", imem_addr, 32'h0);
    reset = 0; id_ready = 1;

    // Pseudo-random tail, checked only by the model.
    for (int i = 0; i < 300; i++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 63) * 4) + (($urandom_range(0, 5) == 0) ? 2 : 0);
      reset          = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 0; redirect_valid = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
